// File: rtl/ex_mem_pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: exception codes,
// FSM state encoding and the branch-resolution helper.
package ex_mem_pipe_pkg;

    localparam logic [31:0] EXC_NONE      = 32'h0000_0000;
    localparam logic [31:0] EXC_OVERFLOW  = 32'h0000_0001;
    localparam logic [31:0] EXC_UNDERFLOW = 32'h0000_0002;

    typedef enum logic {
        EXMEM_RUN      = 1'b0,
        EXMEM_EXC_HOLD = 1'b1
    } exmem_state_e;

    // beq is taken on zero, bne on non-zero
    function automatic logic branch_resolve(input logic alu_zero, input logic branch_ne);
        return alu_zero ^ branch_ne;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_if.sv
// Execute-side and memory-side valid/ready buses of the EX/MEM stage.
// master = surrounding pipeline, slave = the EX/MEM stage itself.
interface ex_mem_pipe_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  ex_valid;
    logic                  ex_ready;
    logic [XLEN-1:0]       ex_alu_result;
    logic                  ex_alu_zero;
    logic [31:0]           ex_exc_code;
    logic [XLEN-1:0]       ex_pc;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic [XLEN-1:0]       ex_store_data;
    logic                  ex_is_branch;
    logic                  ex_branch_ne;
    logic [XLEN-1:0]       ex_branch_target;

    logic                  mem_ready;
    logic                  mem_valid;
    logic [XLEN-1:0]       mem_alu_result;
    logic [XLEN-1:0]       mem_store_data;
    logic [XLEN-1:0]       mem_pc;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_reg_write;
    logic                  mem_mem_read;
    logic                  mem_mem_write;

    modport master (
        output ex_valid, ex_alu_result, ex_alu_zero, ex_exc_code, ex_pc, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data,
               ex_is_branch, ex_branch_ne, ex_branch_target, mem_ready,
        input  ex_ready, mem_valid, mem_alu_result, mem_store_data, mem_pc, mem_rd,
               mem_reg_write, mem_mem_read, mem_mem_write
    );

    modport slave (
        input  ex_valid, ex_alu_result, ex_alu_zero, ex_exc_code, ex_pc, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data,
               ex_is_branch, ex_branch_ne, ex_branch_target, mem_ready,
        output ex_ready, mem_valid, mem_alu_result, mem_store_data, mem_pc, mem_rd,
               mem_reg_write, mem_mem_read, mem_mem_write
    );

endinterface

// File: rtl/ex_mem_perf.sv
// Performance counter bank for the EX/MEM stage (present only when
// EX_MEM_PERF_CNT_EN is defined); all counters wrap at 2^32.
module ex_mem_perf (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_accepted,
    input  logic        inc_stall,
    input  logic        inc_exception,
    output logic [31:0] perf_accepted,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_exceptions
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_accepted     <= '0;
            perf_stall_cycles <= '0;
            perf_exceptions   <= '0;
        end else begin
            if (inc_accepted)  perf_accepted     <= perf_accepted + 32'd1;
            if (inc_stall)     perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (inc_exception) perf_exceptions   <= perf_exceptions + 32'd1;
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline stage: one-entry buffer, branch resolution, sticky exception
// capture and forwarding tap. Optional counters under EX_MEM_PERF_CNT_EN.
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    ex_mem_pipe_if.slave          bus,
    input  logic                  flush,
    output logic                  branch_taken,
    output logic [XLEN-1:0]       branch_target,
    output logic                  exc_pending,
    output logic [31:0]           exc_code_q,
    output logic [XLEN-1:0]       exc_pc_q,
    input  logic                  exc_ack,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]       fwd_data
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [31:0]           perf_accepted,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_exceptions
`endif
);

    exmem_state_e state, state_next;
    logic         accept;
    logic         exc_in;
    logic         take_ok;

    assign accept  = bus.ex_valid && bus.ex_ready;
    assign exc_in  = accept && (bus.ex_exc_code != EXC_NONE);
    assign take_ok = accept && (bus.ex_exc_code == EXC_NONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= EXMEM_RUN;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            EXMEM_RUN:      if (exc_in)  state_next = EXMEM_EXC_HOLD;
            EXMEM_EXC_HOLD: if (exc_ack) state_next = EXMEM_RUN;
            default:        state_next = EXMEM_RUN;
        endcase
    end

    always_comb begin
        bus.ex_ready = (state == EXMEM_RUN) && !flush && (!bus.mem_valid || bus.mem_ready);
    end

    // Payload is only rewritten on accept; a drain merely clears mem_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.mem_valid      <= 1'b0;
            bus.mem_alu_result <= '0;
            bus.mem_store_data <= '0;
            bus.mem_pc         <= '0;
            bus.mem_rd         <= '0;
            bus.mem_reg_write  <= 1'b0;
            bus.mem_mem_read   <= 1'b0;
            bus.mem_mem_write  <= 1'b0;
            branch_taken       <= 1'b0;
            branch_target      <= '0;
        end else if (flush) begin
            bus.mem_valid <= 1'b0;
            branch_taken  <= 1'b0;
        end else if (take_ok) begin
            bus.mem_valid      <= 1'b1;
            bus.mem_alu_result <= bus.ex_alu_result;
            bus.mem_store_data <= bus.ex_store_data;
            bus.mem_pc         <= bus.ex_pc;
            bus.mem_rd         <= bus.ex_rd;
            bus.mem_reg_write  <= bus.ex_reg_write && !bus.ex_is_branch;
            bus.mem_mem_read   <= bus.ex_mem_read  && !bus.ex_is_branch;
            bus.mem_mem_write  <= bus.ex_mem_write && !bus.ex_is_branch;
            branch_taken       <= bus.ex_is_branch &&
                                  branch_resolve(bus.ex_alu_zero, bus.ex_branch_ne);
            if (bus.ex_is_branch && branch_resolve(bus.ex_alu_zero, bus.ex_branch_ne))
                branch_target <= bus.ex_branch_target;
        end else begin
            branch_taken <= 1'b0;
            if (bus.mem_ready) bus.mem_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_pending <= 1'b0;
            exc_code_q  <= '0;
            exc_pc_q    <= '0;
        end else if (exc_in) begin
            exc_pending <= 1'b1;
            exc_code_q  <= bus.ex_exc_code;
            exc_pc_q    <= bus.ex_pc;
        end else if ((state == EXMEM_EXC_HOLD) && exc_ack) begin
            exc_pending <= 1'b0;
        end
    end

    assign fwd_valid = bus.mem_valid && bus.mem_reg_write && (bus.mem_rd != '0);
    assign fwd_rd    = bus.mem_rd;
    assign fwd_data  = bus.mem_alu_result;

`ifdef EX_MEM_PERF_CNT_EN
    logic stall;
    assign stall = bus.ex_valid && !bus.ex_ready;

    ex_mem_perf u_perf (
        .clk               (clk),
        .reset             (reset),
        .inc_accepted      (take_ok),
        .inc_stall         (stall),
        .inc_exception     (exc_in),
        .perf_accepted     (perf_accepted),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_exceptions   (perf_exceptions)
    );
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: directed scenarios plus random traffic
// against a queue-based transaction model of the stage.
module tb_ex_mem_pipe;
    import ex_mem_pipe_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            exc_ack;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            exc_pending;
    logic [31:0]     exc_code_q;
    logic [XLEN-1:0] exc_pc_q;
    logic            fwd_valid;
    logic [RW-1:0]   fwd_rd;
    logic [XLEN-1:0] fwd_data;
`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0]     perf_accepted, perf_stall_cycles, perf_exceptions;
`endif

    always #5 clk = ~clk;

    ex_mem_pipe_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();

    ex_mem_pipe #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus),
        .flush             (flush),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .exc_pending       (exc_pending),
        .exc_code_q        (exc_code_q),
        .exc_pc_q          (exc_pc_q),
        .exc_ack           (exc_ack),
        .fwd_valid         (fwd_valid),
        .fwd_rd            (fwd_rd),
        .fwd_data          (fwd_data)
`ifdef EX_MEM_PERF_CNT_EN
        ,
        .perf_accepted     (perf_accepted),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_exceptions   (perf_exceptions)
`endif
    );

    typedef struct {
        logic [31:0]   alu;
        logic [31:0]   sd;
        logic [31:0]   pc;
        logic [RW-1:0] rd;
        logic          rw, mr, mw;
    } entry_t;

    // Model: the buffer is a queue of at most one instruction; an unacknowledged
    // exception stalls the stage.
    entry_t      buf_q[$];
    bit          m_pend;
    logic [31:0] m_code, m_epc, m_tgt;
    bit          m_pulse;
    logic [31:0] m_acc, m_stall, m_exc;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_ready();
        return !m_pend && !flush && (buf_q.size() == 0 || bus.mem_ready);
    endfunction

    task automatic model_reset();
        buf_q.delete();
        m_pend = 0; m_code = '0; m_epc = '0; m_tgt = '0; m_pulse = 0;
        m_acc = '0; m_stall = '0; m_exc = '0;
    endtask

    task automatic model_edge();
        bit     rdy, take, was_pend, eq;
        entry_t e;
        rdy      = model_ready();
        take     = bus.ex_valid && rdy;
        was_pend = m_pend;
        if (bus.ex_valid && !rdy) m_stall++;
        m_pulse = 0;
        if (flush) begin
            buf_q.delete();
        end else begin
            if (bus.mem_ready && buf_q.size() != 0) void'(buf_q.pop_front());
            if (take && bus.ex_exc_code != 0) begin
                m_pend = 1; m_code = bus.ex_exc_code; m_epc = bus.ex_pc; m_exc++;
            end else if (take) begin
                e.alu = bus.ex_alu_result; e.sd = bus.ex_store_data; e.pc = bus.ex_pc;
                e.rd  = bus.ex_rd;
                e.rw  = bus.ex_is_branch ? 1'b0 : bus.ex_reg_write;
                e.mr  = bus.ex_is_branch ? 1'b0 : bus.ex_mem_read;
                e.mw  = bus.ex_is_branch ? 1'b0 : bus.ex_mem_write;
                buf_q.push_back(e);
                m_acc++;
                eq = bus.ex_alu_zero;
                if (bus.ex_is_branch && (bus.ex_branch_ne ? !eq : eq)) begin
                    m_pulse = 1; m_tgt = bus.ex_branch_target;
                end
            end
        end
        if (was_pend && exc_ack) m_pend = 0;
    endtask

    task automatic check_outputs();
        bit has;
        has = buf_q.size() != 0;
        check("mem_valid", bus.mem_valid, has);
        if (has) begin
            check("mem_alu_result", bus.mem_alu_result, buf_q[0].alu);
            check("mem_store_data", bus.mem_store_data, buf_q[0].sd);
            check("mem_pc",         bus.mem_pc,         buf_q[0].pc);
            check("mem_rd",         bus.mem_rd,         buf_q[0].rd);
            check("mem_reg_write",  bus.mem_reg_write,  buf_q[0].rw);
            check("mem_mem_read",   bus.mem_mem_read,   buf_q[0].mr);
            check("mem_mem_write",  bus.mem_mem_write,  buf_q[0].mw);
            check("fwd_rd",         fwd_rd,             buf_q[0].rd);
            check("fwd_data",       fwd_data,           buf_q[0].alu);
        end
        check("fwd_valid", fwd_valid, has && buf_q[0].rw && buf_q[0].rd != 0);
        check("branch_taken", branch_taken, m_pulse);
        if (m_pulse) check("branch_target", branch_target, m_tgt);
        check("exc_pending", exc_pending, m_pend);
        check("exc_code_q",  exc_code_q,  m_code);
        check("exc_pc_q",    exc_pc_q,    m_epc);
`ifdef EX_MEM_PERF_CNT_EN
        check("perf_accepted",     perf_accepted,     m_acc);
        check("perf_stall_cycles", perf_stall_cycles, m_stall);
        check("perf_exceptions",   perf_exceptions,   m_exc);
`endif
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        #1;
        check("ex_ready", bus.ex_ready, model_ready());
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.ex_valid = 0; bus.ex_alu_result = '0; bus.ex_alu_zero = 0; bus.ex_exc_code = '0;
        bus.ex_pc = '0; bus.ex_rd = '0; bus.ex_reg_write = 0; bus.ex_mem_read = 0;
        bus.ex_mem_write = 0; bus.ex_store_data = '0; bus.ex_is_branch = 0;
        bus.ex_branch_ne = 0; bus.ex_branch_target = '0; bus.mem_ready = 1;
        flush = 0; exc_ack = 0;
    endtask

    task automatic set_ex(input logic [31:0] alu, input logic [RW-1:0] rd, input logic rw,
                          input logic [31:0] exc, input logic [31:0] pc);
        bus.ex_valid = 1; bus.ex_alu_result = alu; bus.ex_rd = rd; bus.ex_reg_write = rw;
        bus.ex_exc_code = exc; bus.ex_pc = pc; bus.ex_store_data = alu ^ 32'hA5A5_0000;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_valid"},   bus.mem_valid,      64'd0);
        check({tag, "_mem_alu"},     bus.mem_alu_result, 64'd0);
        check({tag, "_mem_pc"},      bus.mem_pc,         64'd0);
        check({tag, "_branch"},      branch_taken,       64'd0);
        check({tag, "_exc_pending"}, exc_pending,        64'd0);
        check({tag, "_exc_code"},    exc_code_q,         64'd0);
        check({tag, "_exc_pc"},      exc_pc_q,           64'd0);
        check({tag, "_fwd_valid"},   fwd_valid,          64'd0);
`ifdef EX_MEM_PERF_CNT_EN
        check({tag, "_perf_acc"},    perf_accepted,      64'd0);
        check({tag, "_perf_stall"},  perf_stall_cycles,  64'd0);
        check({tag, "_perf_exc"},    perf_exceptions,    64'd0);
`endif
    endtask

    initial begin
        logic [31:0] stall0;
        idle();
        model_reset();
        reset = 0;
        #12;
        check_all_zero("reset");
        check("reset_ex_ready", bus.ex_ready, 64'd1);
        @(negedge clk);
        reset = 1;

        // Add result reaches the memory side one edge later
        set_ex(32'h12, 5'd3, 1, EXC_NONE, 32'h10);
        step();
        check("add_mem_valid", bus.mem_valid, 64'd1);
        check("add_alu",       bus.mem_alu_result, 64'h12);
        check("add_fwd_valid", fwd_valid, 64'd1);
        check("add_fwd_rd",    fwd_rd, 64'd3);

        // Backpressure: five stalled cycles, then back-to-back replacement
        stall0 = m_stall;
        set_ex(32'h34, 5'd4, 1, EXC_NONE, 32'h14);
        bus.mem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_payload", bus.mem_alu_result, 64'h12);
        end
        check("bp_stall_count", m_stall - stall0, 64'd5);
        bus.mem_ready = 1;
        step();
        check("bp_replace_valid", bus.mem_valid, 64'd1);
        check("bp_replace_alu",   bus.mem_alu_result, 64'h34);

        // Branch taken on equal, then the same branch not taken
        set_ex(32'h0, 5'd7, 1, EXC_NONE, 32'h20);
        bus.ex_is_branch = 1; bus.ex_branch_ne = 0; bus.ex_alu_zero = 1;
        bus.ex_branch_target = 32'h400;
        step();
        check("br_taken",  branch_taken, 64'd1);
        check("br_target", branch_target, 64'h400);
        check("br_no_rw",  bus.mem_reg_write, 64'd0);
        idle();
        step();
        check("br_pulse_once", branch_taken, 64'd0);
        set_ex(32'h1, 5'd7, 1, EXC_NONE, 32'h20);
        bus.ex_is_branch = 1; bus.ex_branch_ne = 0; bus.ex_alu_zero = 0;
        bus.ex_branch_target = 32'h400;
        step();
        check("br_not_taken", branch_taken, 64'd0);

        // Exception capture, stall in hold, flush in hold, acknowledge
        idle();
        set_ex(32'h55, 5'd9, 1, EXC_OVERFLOW, 32'h80);
        step();
        check("exc_no_valid", bus.mem_valid, 64'd0);
        check("exc_pending",  exc_pending, 64'd1);
        check("exc_code",     exc_code_q, {32'd0, EXC_OVERFLOW});
        check("exc_pc",       exc_pc_q, 64'h80);
        set_ex(32'h66, 5'd2, 1, EXC_NONE, 32'h84);
        for (int i = 0; i < 3; i++) step();
        check("exc_hold_ready", bus.ex_ready, 64'd0);
        flush = 1;
        step();
        check("exc_flush_keeps", exc_pending, 64'd1);
        flush = 0;
        idle();
        exc_ack = 1;
        step();
        exc_ack = 0;
        #1;
        check("ack_pending_clr", exc_pending, 64'd0);
        check("ack_ready",       bus.ex_ready, 64'd1);
        check("ack_code_kept",   exc_code_q, {32'd0, EXC_OVERFLOW});
        @(negedge clk);

        // Flush plus accept in the same cycle drops the instruction
        set_ex(32'h77, 5'd5, 1, EXC_NONE, 32'h90);
        flush = 1;
        step();
        check("flush_drop", bus.mem_valid, 64'd0);
        idle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bus.ex_valid         = ($urandom_range(0, 9) < 7);
            bus.ex_alu_result    = $urandom;
            bus.ex_alu_zero      = $urandom_range(0, 1);
            bus.ex_pc            = $urandom;
            bus.ex_rd            = RW'($urandom_range(0, 31));
            bus.ex_reg_write     = $urandom_range(0, 1);
            bus.ex_mem_read      = $urandom_range(0, 1);
            bus.ex_mem_write     = $urandom_range(0, 1);
            bus.ex_store_data    = $urandom;
            bus.ex_is_branch     = ($urandom_range(0, 9) < 3);
            bus.ex_branch_ne     = $urandom_range(0, 1);
            bus.ex_branch_target = $urandom;
            case ($urandom_range(0, 19))
                0:       bus.ex_exc_code = EXC_OVERFLOW;
                1:       bus.ex_exc_code = EXC_UNDERFLOW;
                default: bus.ex_exc_code = EXC_NONE;
            endcase
            bus.mem_ready = ($urandom_range(0, 9) < 6);
            flush         = ($urandom_range(0, 99) < 8);
            exc_ack       = ($urandom_range(0, 9) < 3);
            step();
        end

        // Asynchronous reset while an exception is held
        idle();
        set_ex(32'h99, 5'd1, 1, EXC_UNDERFLOW, 32'hC0);
        step();
        check("pre_reset_pending", exc_pending, 64'd1);
        idle();
        #3;
        reset = 0;
        #1;
        model_reset();
        check_all_zero("async_reset");
        @(negedge clk);
        reset = 1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
